muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers, beside the execute stage ALU.

---
 rtl/muldiv_sequencer_pkg.sv | 35 +++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, FSM encodings and op-decode helpers for the iterative
// multiply/divide unit.
package muldiv_sequencer_pkg;

  // md op codes as delivered by the id->ex controls
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MFHI  = 3'd4;
  localparam logic [2:0] MD_OP_MFLO  = 3'd5;
  localparam logic [2:0] MD_OP_MTHI  = 3'd6;
  localparam logic [2:0] MD_OP_MTLO  = 3'd7;

  // FSM encodings
  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_CALC = 2'd1;
  localparam logic [1:0] MD_ST_FIX  = 2'd2;

  // Ops 0..3 start a multi-cycle computation
  function automatic logic md_is_calc(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Among calc ops, bit 1 selects divide
  function automatic logic md_is_div(input logic [2:0] op);
    return op[1];
  endfunction

  // Among calc ops, even codes are the signed variants
  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers. Multiplies by 32-step
// shift-add and divides by 32-step restoring division on operand magnitudes,
// then applies sign fixup in a single FIX cycle before writing HI/LO.
//
// Handshake: an md op is accepted on a rising edge when
// md_valid_ex & ~stall_ex & ~kill_ex; stall_ex = md_valid_ex & busy, so the
// issuing stage holds the op until the unit is idle. kill_ex aborts an
// in-flight computation (HI/LO untouched) and drops any request that cycle.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_valid_ex,
  input  logic [2:0]            md_op_ex,
  input  logic [DATA_WIDTH-1:0] reg_s_data_ex,
  input  logic [DATA_WIDTH-1:0] reg_t_data_ex,
  input  logic                  kill_ex,
  output logic                  stall_ex,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] md_data_ex,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [CW-1:0]         count;
  // acc: running high product / partial remainder
  // low: multiplier shifting out / quotient shifting in
  // operand: multiplicand / divisor magnitude
  logic [DATA_WIDTH-1:0] acc, low, operand;
  logic                  op_div, neg_q, neg_r, div_zero;

  logic                  accept, start, sgn;
  logic [DATA_WIDTH-1:0] rs_abs, rt_abs;
  logic [DATA_WIDTH:0]   mul_sum, rem_sh;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_diff;
  logic [2*DATA_WIDTH-1:0] prod, prod_neg;

  assign busy      = (state != MD_ST_IDLE);
  assign stall_ex  = md_valid_ex & busy;
  assign fsm_state = state;
  assign accept    = md_valid_ex & ~stall_ex & ~kill_ex;
  assign start     = accept & md_is_calc(md_op_ex);
  assign sgn       = md_is_signed(md_op_ex);
  assign rs_abs    = (sgn && reg_s_data_ex[DATA_WIDTH-1]) ? ('0 - reg_s_data_ex) : reg_s_data_ex;
  assign rt_abs    = (sgn && reg_t_data_ex[DATA_WIDTH-1]) ? ('0 - reg_t_data_ex) : reg_t_data_ex;

  // One datapath step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    rem_sh   = {acc, low[DATA_WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, operand});
    div_diff = rem_sh[DATA_WIDTH-1:0] - operand;
    prod     = {acc, low};
    prod_neg = '0 - prod;
  end

  // MFHI/MFLO read data, straight from HI/LO
  always_comb begin
    md_data_ex = '0;
    if (md_valid_ex && md_op_ex == MD_OP_MFHI) md_data_ex = hi;
    else if (md_valid_ex && md_op_ex == MD_OP_MFLO) md_data_ex = lo;
  end

  // FSM, step counter, operand latches and HI/LO writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_ST_IDLE;
      count    <= '0;
      acc      <= '0;
      low      <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (kill_ex && busy) begin
      state <= MD_ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_ST_IDLE: begin
          if (accept && md_op_ex == MD_OP_MTHI) hi <= reg_s_data_ex;
          if (accept && md_op_ex == MD_OP_MTLO) lo <= reg_s_data_ex;
          if (start) begin
            state    <= MD_ST_CALC;
            count    <= '0;
            acc      <= '0;
            op_div   <= md_is_div(md_op_ex);
            div_zero <= md_is_div(md_op_ex) && (reg_t_data_ex == '0);
            neg_r    <= sgn && reg_s_data_ex[DATA_WIDTH-1];
            neg_q    <= sgn && (reg_s_data_ex[DATA_WIDTH-1] ^ reg_t_data_ex[DATA_WIDTH-1])
                        && !(md_is_div(md_op_ex) && (reg_t_data_ex == '0));
            if (md_is_div(md_op_ex)) begin
              low     <= rs_abs;
              operand <= rt_abs;
            end else begin
              low     <= rt_abs;
              operand <= rs_abs;
            end
          end
        end
        MD_ST_CALC: begin
          if (op_div) begin
            acc <= div_ge ? div_diff : rem_sh[DATA_WIDTH-1:0];
            low <= {low[DATA_WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[DATA_WIDTH:1];
            low <= {mul_sum[0], low[DATA_WIDTH-1:1]};
          end
          count <= count + CW'(1);
          if (count == LAST_STEP) state <= MD_ST_FIX;
        end
        MD_ST_FIX: begin
          if (op_div) begin
            lo <= div_zero ? '1 : (neg_q ? ('0 - low) : low);
            hi <= neg_r ? ('0 - acc) : acc;
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end
          count <= '0;
          state <= MD_ST_IDLE;
        end
        default: begin
          state <= MD_ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of multiply/divide vectors with known
// results, a short random phase checked against a behavioural model, and
// hand-written sequences for stall, kill and mid-operation reset.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;
  localparam int BUSY_CYCLES = 33;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         md_valid_ex;
  logic [2:0]   md_op_ex;
  logic [W-1:0] reg_s_data_ex, reg_t_data_ex;
  logic         kill_ex;
  logic         stall_ex, busy;
  logic [W-1:0] md_data_ex, hi, lo;
  logic [1:0]   fsm_state;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .md_valid_ex(md_valid_ex), .md_op_ex(md_op_ex),
    .reg_s_data_ex(reg_s_data_ex), .reg_t_data_ex(reg_t_data_ex), .kill_ex(kill_ex),
    .stall_ex(stall_ex), .busy(busy), .md_data_ex(md_data_ex), .hi(hi), .lo(lo),
    .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [W-1:0] rs, rt, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one md op for a single accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    md_valid_ex   = 1'b1;
    md_op_ex      = op;
    reg_s_data_ex = rs;
    reg_t_data_ex = rt;
    tick();
    md_valid_ex = 1'b0;
  endtask

  // count busy cycles (sampled on falling edges) until idle, bounded
  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (cycles < TIMEOUT) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cycles++;
    end
    if (cycles >= TIMEOUT) check({name, "_timeout"}, 64'(cycles), 64'(BUSY_CYCLES));
  endtask

  // behavioural reference: native arithmetic, not the shift/add algorithm
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] rs,
                                        input logic [W-1:0] rt);
    int a, b, q, r;
    logic [63:0] res;
    a = rs;
    b = rt;
    res = '0;
    case (op)
      MD_OP_MULT:  res = 64'(longint'(a) * longint'(b));
      MD_OP_MULTU: res = 64'(rs) * 64'(rt);
      MD_OP_DIV: begin
        if (rt == 0) res = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = a / b;
          r = a % b;
          res = {32'(r), 32'(q)};
        end
      end
      MD_OP_DIVU: begin
        if (rt == 0) res = {rs, 32'hFFFF_FFFF};
        else res = {rs % rt, rs / rt};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // run one calc op through the scoreboard: push on issue, pop on completion
  task automatic run_calc(input string name, input logic [2:0] op, input logic [W-1:0] rs,
                          input logic [W-1:0] rt, input logic [63:0] exp);
    int cyc;
    logic [63:0] e;
    exp_q.push_back(exp);
    issue(op, rs, rt);
    wait_idle(name, cyc);
    check({name, "_busy_cycles"}, 64'(cyc), 64'(BUSY_CYCLES));
    e = exp_q.pop_front();
    check({name, "_hilo"}, {hi, lo}, e);
    tick();
  endtask

  initial begin
    int cyc;
    logic [2:0] rop;
    logic [W-1:0] rrs, rrt;
    logic [W-1:0] lo_before;

    vecs[0]  = '{"multu_max",  MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"mult_neg",   MD_OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"div_neg",    MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_zero",  MD_OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4]  = '{"div_ovf",    MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[5]  = '{"divu_basic", MD_OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6]  = '{"multu_carry",MD_OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0};
    vecs[7]  = '{"div_negdiv", MD_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{"mult_bothneg",MD_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
    vecs[9]  = '{"div_zero_s", MD_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{"mult_maxpos",MD_OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

    // reset
    rst = 1'b1; md_valid_ex = 1'b0; md_op_ex = '0; kill_ex = 1'b0;
    reg_s_data_ex = '0; reg_t_data_ex = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_stall", 64'(stall_ex), 64'(0));
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_md_data", 64'(md_data_ex), 64'h0);
    check("reset_state", 64'(fsm_state), 64'(MD_ST_IDLE));
    tick();

    // MT then MF, same-cycle read
    issue(MD_OP_MTHI, 32'hCAFE_0001, 32'h0);
    issue(MD_OP_MTLO, 32'hBEEF_0002, 32'h0);
    check("mt_hilo", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    md_valid_ex = 1'b1; md_op_ex = MD_OP_MFHI; #1;
    check("mfhi_data", 64'(md_data_ex), 64'hCAFE_0001);
    md_op_ex = MD_OP_MFLO; #1;
    check("mflo_data", 64'(md_data_ex), 64'hBEEF_0002);
    check("mf_no_stall", 64'(stall_ex), 64'(0));
    md_valid_ex = 1'b0;
    tick();

    // table-driven vectors
    for (int i = 0; i < 11; i++)
      run_calc(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].exp_hi, vecs[i].exp_lo});

    // random vectors against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      rrs = $urandom;
      rrt = (i == 3) ? 32'h0 : 32'($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
      run_calc($sformatf("rand%0d", i), rop, rrs, rrt, model(rop, rrs, rrt));
    end

    // MFLO issued while a MULT is in flight: stalled until completion
    exp_q.push_back(model(MD_OP_MULT, 32'd123456, 32'hFFFF_FF00));
    issue(MD_OP_MULT, 32'd123456, 32'hFFFF_FF00);
    check("inflight_state", 64'(fsm_state), 64'(MD_ST_CALC));
    repeat (4) tick();
    md_valid_ex = 1'b1; md_op_ex = MD_OP_MFLO;
    cyc = 0;
    while (cyc < TIMEOUT) begin
      @(negedge clk);
      if (stall_ex !== 1'b1) break;
      cyc++;
    end
    check("mflo_stall_cycles", 64'(cyc), 64'(BUSY_CYCLES - 4));
    lo_before = exp_q[0][W-1:0];
    check("mflo_after_done", 64'(md_data_ex), 64'(lo_before));
    check("mflo_hilo", {hi, lo}, exp_q.pop_front());
    tick();
    md_valid_ex = 1'b0;

    // kill mid-divide keeps prior HI/LO
    issue(MD_OP_MTHI, 32'h1234, 32'h0);
    issue(MD_OP_MTLO, 32'h5678, 32'h0);
    issue(MD_OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    kill_ex = 1'b1;
    tick();
    kill_ex = 1'b0;
    @(negedge clk);
    check("kill_busy", 64'(busy), 64'(0));
    check("kill_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    repeat (40) tick();
    check("kill_hilo_later", {hi, lo}, 64'h0000_1234_0000_5678);

    // kill in idle drops an MT request
    kill_ex = 1'b1;
    issue(MD_OP_MTHI, 32'hDEAD, 32'h0);
    kill_ex = 1'b0;
    check("kill_idle_mthi", 64'(hi), 64'h1234);
    check("kill_idle_busy", 64'(busy), 64'(0));

    // reset mid-operation discards the result
    issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'h3);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_stall", 64'(stall_ex), 64'(0));
    tick();
    issue(MD_OP_MTHI, 32'hA5, 32'h0);
    check("rst_then_mthi", 64'(hi), 64'hA5);
    repeat (40) tick();
    check("rst_no_late_write", {hi, lo}, 64'h0000_00A5_0000_0000);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
